// File: rtl/mem_read_arbiter_if.sv
// Read channel bundle: AXI-lite style address request plus single data beat.
// master drives address/rready, slave drives arready and the data beat.
interface mem_read_arbiter_if #(
    parameter int DATA_LEN = 32
);
    logic                arvalid;
    logic                arready;
    logic [DATA_LEN-1:0] raddr;
    logic                rvalid;
    logic                rready;
    logic [2:0]          rresp;
    logic [DATA_LEN-1:0] rdata;

    modport master (
        output arvalid,
        output raddr,
        output rready,
        input  arready,
        input  rvalid,
        input  rresp,
        input  rdata
    );

    modport slave (
        input  arvalid,
        input  raddr,
        input  rready,
        output arready,
        output rvalid,
        output rresp,
        output rdata
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between icache refill and LSU loads.
// ARB_ROUND_ROBIN_EN selects round-robin; undefined gives fixed LSU priority.
module mem_read_arbiter #(
    parameter int DATA_LEN = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    mem_read_arbiter_if.slave    icache,
    mem_read_arbiter_if.slave    lsu,
    mem_read_arbiter_if.master   mem
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_e;

    localparam logic GNT_ICACHE = 1'b0;
    localparam logic GNT_LSU    = 1'b1;

    arb_state_e          state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_arvalid_q, mem_arvalid_d;
    logic [DATA_LEN-1:0] mem_raddr_q, mem_raddr_d;

    logic                win;
    logic                win_valid;
    logic [DATA_LEN-1:0] win_raddr;

    // Pick the requester that would be granted in IDLE this cycle
    always_comb begin
        win = GNT_ICACHE;
`ifdef ARB_ROUND_ROBIN_EN
        unique case (1'b1)
            icache.arvalid && lsu.arvalid: win = ~last_grant_q;
            icache.arvalid:                win = GNT_ICACHE;
            lsu.arvalid:                   win = GNT_LSU;
            default:                       win = ~last_grant_q;
        endcase
`else
        if (lsu.arvalid) begin
            win = GNT_LSU;
        end
`endif
        win_valid = (win == GNT_LSU) ? lsu.arvalid : icache.arvalid;
        win_raddr = (win == GNT_LSU) ? lsu.raddr : icache.raddr;
    end

    // Next-state and register updates for the arbitration FSM
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        mem_arvalid_d = mem_arvalid_q;
        mem_raddr_d   = mem_raddr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    grant_d       = win;
                    mem_raddr_d   = win_raddr;
                    mem_arvalid_d = 1'b1;
                    state_d       = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (mem_arvalid_q && mem.arready) begin
                    mem_arvalid_d = 1'b0;
                    state_d       = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (mem.rvalid && mem.rready) begin
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_q;
`endif
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d       = ARB_IDLE;
                mem_arvalid_d = 1'b0;
            end
        endcase
    end

    // Requester-facing handshakes and data-beat routing
    always_comb begin
        icache.arready = 1'b0;
        lsu.arready    = 1'b0;
        icache.rvalid  = 1'b0;
        icache.rdata   = '0;
        icache.rresp   = 3'd0;
        lsu.rvalid     = 1'b0;
        lsu.rdata      = '0;
        lsu.rresp      = 3'd0;
        mem.rready     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                icache.arready = (win == GNT_ICACHE);
                lsu.arready    = (win == GNT_LSU);
            end
            ARB_DATA: begin
                if (grant_q == GNT_LSU) begin
                    mem.rready = lsu.rready;
                    lsu.rvalid = mem.rvalid;
                    lsu.rdata  = mem.rdata;
                    lsu.rresp  = mem.rresp;
                end else begin
                    mem.rready    = icache.rready;
                    icache.rvalid = mem.rvalid;
                    icache.rdata  = mem.rdata;
                    icache.rresp  = mem.rresp;
                end
            end
            default: begin
                mem.rready = 1'b0;
            end
        endcase
    end

    // State, grant and registered memory address channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            grant_q       <= GNT_ICACHE;
            last_grant_q  <= GNT_LSU;
            mem_arvalid_q <= 1'b0;
            mem_raddr_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            mem_arvalid_q <= mem_arvalid_d;
            mem_raddr_q   <= mem_raddr_d;
        end
    end

    assign mem.arvalid = mem_arvalid_q;
    assign mem.raddr   = mem_raddr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter.
// Data beats are checked through per-requester scoreboard queues.
module tb_mem_read_arbiter;

    localparam int DL = 32;

    typedef struct packed {
        logic [DL-1:0] data;
        logic [2:0]    resp;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.DATA_LEN(DL)) ic ();
    mem_read_arbiter_if #(.DATA_LEN(DL)) ls ();
    mem_read_arbiter_if #(.DATA_LEN(DL)) mm ();

    mem_read_arbiter #(.DATA_LEN(DL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .icache (ic),
        .lsu    (ls),
        .mem    (mm)
    );

    beat_t ic_q[$];
    beat_t ls_q[$];
    beat_t ic_exp;
    beat_t ls_exp;
    int    asserts  = 0;
    int    failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ic.arvalid = 1'b0;
        ic.raddr   = '0;
        ic.rready  = 1'b0;
        ls.arvalid = 1'b0;
        ls.raddr   = '0;
        ls.rready  = 1'b0;
        mm.arready = 1'b0;
        mm.rvalid  = 1'b0;
        mm.rresp   = 3'd0;
        mm.rdata   = '0;
    endtask

    // Memory side of one transaction, starting in ARB_ADDR
    task automatic mem_beat(input logic [DL-1:0] d, input logic [2:0] r);
        mm.arready = 1'b1;
        tick();
        mm.arready = 1'b0;
        mm.rvalid  = 1'b1;
        mm.rdata   = d;
        mm.rresp   = r;
        ic.rready  = 1'b1;
        ls.rready  = 1'b1;
        tick();
        mm.rvalid  = 1'b0;
        mm.rdata   = '0;
        mm.rresp   = 3'd0;
        ic.rready  = 1'b0;
        ls.rready  = 1'b0;
    endtask

    // Scoreboard: every delivered beat must match the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ic.rvalid === 1'b1 && ic.rready === 1'b1) begin
                asserts++;
                if (ic_q.size() == 0) begin
                    failures++;
                    $display("FAIL ic_unexpected_beat got %h/%0d", ic.rdata, ic.rresp);
                end else begin
                    ic_exp = ic_q.pop_front();
                    if ({ic.rdata, ic.rresp} !== ic_exp) begin
                        failures++;
                        $display("FAIL ic_beat got %h/%0d want %h/%0d",
                                 ic.rdata, ic.rresp, ic_exp.data, ic_exp.resp);
                    end
                end
            end
            if (rst_n === 1'b1 && ls.rvalid === 1'b1 && ls.rready === 1'b1) begin
                asserts++;
                if (ls_q.size() == 0) begin
                    failures++;
                    $display("FAIL ls_unexpected_beat got %h/%0d", ls.rdata, ls.rresp);
                end else begin
                    ls_exp = ls_q.pop_front();
                    if ({ls.rdata, ls.rresp} !== ls_exp) begin
                        failures++;
                        $display("FAIL ls_beat got %h/%0d want %h/%0d",
                                 ls.rdata, ls.rresp, ls_exp.data, ls_exp.resp);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        asserts++;
        if (mm.arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got %b want 0", mm.arvalid); end
        asserts++;
        if (mm.raddr !== 32'h0) begin failures++; $display("FAIL rst_raddr got %h want 0", mm.raddr); end
        asserts++;
        if (mm.rready !== 1'b0) begin failures++; $display("FAIL rst_rready got %b want 0", mm.rready); end
        asserts++;
        if (ic.rvalid !== 1'b0 || ls.rvalid !== 1'b0) begin
            failures++; $display("FAIL rst_rvalid got %b%b want 00", ic.rvalid, ls.rvalid);
        end
        asserts++;
        if (ic.arready !== 1'b1 || ls.arready !== 1'b0) begin
            failures++; $display("FAIL rst_arready got ic=%b ls=%b want 1/0", ic.arready, ls.arready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic          exp_lsu;
        logic [DL-1:0] exp_addr;
        logic [DL-1:0] d;
        tick();
        ic.arvalid = 1'b1;
        ic.raddr   = 32'h0000_1000;
        ls.arvalid = 1'b1;
        ls.raddr   = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            exp_lsu  = i[0];
            exp_addr = exp_lsu ? 32'h0000_2000 : 32'h0000_1000;
            d        = (exp_lsu ? 32'hB000_0000 : 32'hA000_0000) + DL'(i);
            #1;
            asserts++;
            if (ic.arready !== !exp_lsu || ls.arready !== exp_lsu) begin
                failures++;
                $display("FAIL rr_grant%0d got ic=%b ls=%b want lsu=%b", i, ic.arready, ls.arready, exp_lsu);
            end
            if (exp_lsu) ls_q.push_back('{d, 3'd0});
            else         ic_q.push_back('{d, 3'd0});
            tick();
            asserts++;
            if (mm.raddr !== exp_addr) begin
                failures++; $display("FAIL rr_raddr%0d got %h want %h", i, mm.raddr, exp_addr);
            end
            mem_beat(d, 3'd0);
        end
        ic.arvalid = 1'b0;
        ls.arvalid = 1'b0;
    endtask
`else
    task automatic test_fixed_priority();
        tick();
        ic.arvalid = 1'b1;
        ic.raddr   = 32'h0000_1000;
        ls.arvalid = 1'b1;
        ls.raddr   = 32'h0000_2000;
        ls_q.push_back('{32'hB000_0001, 3'd0});
        #1;
        asserts++;
        if (ls.arready !== 1'b1 || ic.arready !== 1'b0) begin
            failures++; $display("FAIL fp_first got ic=%b ls=%b want 0/1", ic.arready, ls.arready);
        end
        tick();
        ls.arvalid = 1'b0;
        #1;
        asserts++;
        if (mm.raddr !== 32'h0000_2000) begin
            failures++; $display("FAIL fp_lsu_raddr got %h want 00002000", mm.raddr);
        end
        asserts++;
        if (ic.arready !== 1'b0) begin
            failures++; $display("FAIL fp_ic_wait got %b want 0", ic.arready);
        end
        mem_beat(32'hB000_0001, 3'd0);
        ic_q.push_back('{32'hA000_0001, 3'd0});
        #1;
        asserts++;
        if (ic.arready !== 1'b1) begin
            failures++; $display("FAIL fp_ic_after got %b want 1", ic.arready);
        end
        tick();
        ic.arvalid = 1'b0;
        #1;
        asserts++;
        if (mm.raddr !== 32'h0000_1000) begin
            failures++; $display("FAIL fp_ic_raddr got %h want 00001000", mm.raddr);
        end
        mem_beat(32'hA000_0001, 3'd0);
    endtask
`endif

    task automatic test_icache_single();
        tick();
        ic.arvalid = 1'b1;
        ic.raddr   = 32'h8000_0010;
        ic_q.push_back('{32'h1234_5678, 3'd0});
        #1;
        asserts++;
        if (ic.arready !== 1'b1 || mm.arvalid !== 1'b0) begin
            failures++; $display("FAIL single_accept got arready=%b arvalid=%b want 1/0", ic.arready, mm.arvalid);
        end
        tick();
        ic.arvalid = 1'b0;
        #1;
        asserts++;
        if (mm.arvalid !== 1'b1) begin
            failures++; $display("FAIL single_arvalid got %b want 1", mm.arvalid);
        end
        asserts++;
        if (mm.raddr !== 32'h8000_0010) begin
            failures++; $display("FAIL single_raddr got %h want 80000010", mm.raddr);
        end
        mem_beat(32'h1234_5678, 3'd0);
    endtask

    task automatic test_addr_stall();
        tick();
        ic.arvalid = 1'b1;
        ic.raddr   = 32'h0000_0040;
        ic_q.push_back('{32'hCAFE_F00D, 3'd0});
        tick();
        ic.arvalid = 1'b0;
        ls.arvalid = 1'b1;
        ls.raddr   = 32'h0000_0080;
        for (int k = 0; k < 5; k++) begin
            #1;
            asserts++;
            if (mm.arvalid !== 1'b1 || mm.raddr !== 32'h0000_0040) begin
                failures++; $display("FAIL stall_hold%0d got %b/%h want 1/00000040", k, mm.arvalid, mm.raddr);
            end
            asserts++;
            if (ic.arready !== 1'b0 || ls.arready !== 1'b0) begin
                failures++; $display("FAIL stall_arready%0d got ic=%b ls=%b want 0/0", k, ic.arready, ls.arready);
            end
            tick();
        end
        ls.arvalid = 1'b0;
        mem_beat(32'hCAFE_F00D, 3'd0);
    endtask

    task automatic test_resp_backpressure();
        tick();
        ic.arvalid = 1'b1;
        ic.raddr   = 32'h0000_0100;
        ic_q.push_back('{32'h0BAD_0BAD, 3'h2});
        tick();
        ic.arvalid = 1'b0;
        mm.arready = 1'b1;
        tick();
        mm.arready = 1'b0;
        mm.rvalid  = 1'b1;
        mm.rdata   = 32'h0BAD_0BAD;
        mm.rresp   = 3'h2;
        ic.rready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            asserts++;
            if (mm.rready !== 1'b0) begin
                failures++; $display("FAIL bp_rready%0d got %b want 0", k, mm.rready);
            end
            asserts++;
            if (ic.rvalid !== 1'b1 || ic.rresp !== 3'h2) begin
                failures++; $display("FAIL bp_rvalid%0d got %b/%0d want 1/2", k, ic.rvalid, ic.rresp);
            end
            tick();
        end
        ic.rready = 1'b1;
        #1;
        asserts++;
        if (mm.rready !== 1'b1) begin
            failures++; $display("FAIL bp_release got %b want 1", mm.rready);
        end
        tick();
        mm.rvalid = 1'b0;
        mm.rdata  = '0;
        mm.rresp  = 3'd0;
        ic.rready = 1'b0;
        #1;
        asserts++;
        if (ic.rvalid !== 1'b0 || (ic.arready | ls.arready) !== 1'b1) begin
            failures++; $display("FAIL bp_idle got rvalid=%b ar=%b%b want 0 and idle", ic.rvalid, ic.arready, ls.arready);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        ic.arvalid = 1'b1;
        ic.raddr   = 32'h0000_0200;
        tick();
        ic.arvalid = 1'b0;
        mm.arready = 1'b1;
        tick();
        mm.arready = 1'b0;
        mm.rvalid  = 1'b1;
        mm.rdata   = 32'hDEAD_BEEF;
        ic.rready  = 1'b0;
        #1;
        asserts++;
        if (ic.rvalid !== 1'b1) begin
            failures++; $display("FAIL mid_in_data got %b want 1", ic.rvalid);
        end
        rst_n = 1'b0;
        tick();
        asserts++;
        if (mm.arvalid !== 1'b0 || mm.raddr !== 32'h0 || mm.rready !== 1'b0) begin
            failures++; $display("FAIL mid_rst_mem got %b/%h/%b want 0/0/0", mm.arvalid, mm.raddr, mm.rready);
        end
        asserts++;
        if (ic.rvalid !== 1'b0 || ic.rdata !== 32'h0 || ic.arready !== 1'b1) begin
            failures++; $display("FAIL mid_rst_ic got %b/%h/%b want 0/0/1", ic.rvalid, ic.rdata, ic.arready);
        end
        mm.rvalid = 1'b0;
        mm.rdata  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ic.arvalid = 1'b1;
        ic.raddr   = 32'h0000_0300;
        ic_q.push_back('{32'h5555_AAAA, 3'd0});
        #1;
        asserts++;
        if (ic.arready !== 1'b1) begin
            failures++; $display("FAIL mid_after_accept got %b want 1", ic.arready);
        end
        tick();
        ic.arvalid = 1'b0;
        #1;
        asserts++;
        if (mm.raddr !== 32'h0000_0300) begin
            failures++; $display("FAIL mid_after_raddr got %h want 00000300", mm.raddr);
        end
        mem_beat(32'h5555_AAAA, 3'd0);
    endtask

    initial begin
        test_reset();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_icache_single();
        test_addr_stall();
        test_resp_backpressure();
        test_reset_mid();
        repeat (2) tick();
        asserts++;
        if (ic_q.size() != 0 || ls_q.size() != 0) begin
            failures++; $display("FAIL sb_drain got ic=%0d ls=%0d want 0/0", ic_q.size(), ls_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
